// File: rtl/osc_clk_seq_if.sv
// Control/status bundle between a clock bring-up sequencer and its controller.
// The master drives requests and the raw lock input; the slave reports CCC status.
interface osc_clk_seq_if;
   logic       start;
   logic       stop;
   logic       pll_lock;
   logic       ccc_en;
   logic       clk_ready;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retry_cnt;

   modport master (
      output start, stop, pll_lock,
      input  ccc_en, clk_ready, fault, state, retry_cnt
   );

   modport slave (
      input  start, stop, pll_lock,
      output ccc_en, clk_ready, fault, state, retry_cnt
   );
endinterface

// File: rtl/osc_clk_seq.sv
// Oscillator/CCC bring-up sequencer: settle, wait for lock with timeout, bounded
// retries through a power-down recovery gap, sticky fault after the last attempt.
module osc_clk_seq #(
   parameter int SETTLE_CYCLES = 1000,
   parameter int LOCK_TIMEOUT  = 4095,
   parameter int RETRY_MAX     = 3
) (
   input  logic         clk,
   input  logic         resetn,
   osc_clk_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTLE    = 3'd1,
      WAIT_LOCK = 3'd2,
      LOCKED    = 3'd3,
      RECOVER   = 3'd4,
      FAULT     = 3'd5
   } state_t;

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] RECOVER_LAST = 16'd15;
   localparam logic [3:0]  RETRY_LIM    = 4'(RETRY_MAX);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [1:0]  sync_q;
   logic        lock_s;
   logic        ccc_en_q, ready_q, fault_q;
   logic        ccc_en_d, ready_d, fault_d;

   // PLL_LOCK is asynchronous to clk; only the second stage is trusted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], bus.pll_lock};
   end
   assign lock_s = sync_q[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         retry_q  <= '0;
         ccc_en_q <= 1'b0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         ccc_en_q <= ccc_en_d;
         ready_q  <= ready_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      if (state_q > FAULT) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.start) begin
         state_d = SETTLE;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 16'd1;
            end
            WAIT_LOCK: begin
               // lock is checked first so it wins a tie with the timeout
               if (lock_s) begin
                  state_d = LOCKED;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_LIM) begin
                     retry_d = retry_q + 4'd1;
                     state_d = RECOVER;
                  end else state_d = FAULT;
               end else cnt_d = cnt_q + 16'd1;
            end
            LOCKED: begin
               if (!lock_s) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_LIM) begin
                     retry_d = retry_q + 4'd1;
                     state_d = RECOVER;
                  end else state_d = FAULT;
               end
            end
            RECOVER: begin
               if (cnt_q == RECOVER_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // status flags are a registered decode of the current state
   always_comb begin
      ccc_en_d = (state_q == WAIT_LOCK) || (state_q == LOCKED);
      ready_d  = (state_q == LOCKED);
      fault_d  = (state_q == FAULT);
   end

   assign bus.ccc_en    = ccc_en_q;
   assign bus.clk_ready = ready_q;
   assign bus.fault     = fault_q;
   assign bus.state     = state_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_osc_clk_seq.sv
// Directed bench for osc_clk_seq with SETTLE_CYCLES=8, LOCK_TIMEOUT=20, RETRY_MAX=2.
// Edge numbering in each task counts from the edge that samples START (edge 0).
module tb_osc_clk_seq;
   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   failures = 0;

   osc_clk_seq_if bus ();

   osc_clk_seq #(.SETTLE_CYCLES(8), .LOCK_TIMEOUT(20), .RETRY_MAX(2)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      step();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      checks++;
      if ({bus.ccc_en, bus.clk_ready, bus.fault, bus.state, bus.retry_cnt} !== 10'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {bus.ccc_en, bus.clk_ready, bus.fault, bus.state, bus.retry_cnt});
      end
      step(); step();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (bus.state !== 3'd0 || bus.ccc_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_autostart cyc=%0d state=%0d ccc_en=%b exp state=0 ccc_en=0", i, bus.state, bus.ccc_en);
         end
      end
   endtask

   task automatic test_nominal();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.state !== 3'd1 || bus.ccc_en !== 1'b0) begin
         failures++;
         $display("FAIL nominal_start state=%0d ccc_en=%b exp state=1 ccc_en=0", bus.state, bus.ccc_en);
      end
      for (int e = 1; e <= 9; e++) begin
         step();
         checks++;
         if (bus.state !== ((e < 8) ? 3'd1 : 3'd2) || bus.ccc_en !== (e == 9)) begin
            failures++;
            $display("FAIL nominal_settle edge=%0d state=%0d ccc_en=%b exp state=%0d ccc_en=%b",
                     e, bus.state, bus.ccc_en, (e < 8) ? 1 : 2, e == 9);
         end
      end
      // WAIT_LOCK entered at edge 8; lock rises 5 cycles later, sampled at edge 14
      for (int e = 10; e <= 13; e++) step();
      bus.pll_lock = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         step();
         checks++;
         if (bus.clk_ready !== (k == 3)) begin
            failures++;
            $display("FAIL nominal_ready t+%0d clk_ready=%b exp=%b", k, bus.clk_ready, k == 3);
         end
      end
      checks++;
      if (bus.state !== 3'd3 || bus.ccc_en !== 1'b1 || bus.retry_cnt !== 4'd0) begin
         failures++;
         $display("FAIL nominal_locked state=%0d ccc_en=%b retry=%0d exp 3/1/0", bus.state, bus.ccc_en, bus.retry_cnt);
      end
   endtask

   task automatic test_lock_loss();
      logic [2:0] es;
      bus.pll_lock = 1'b0;
      step();
      bus.pll_lock = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         es = (k == 1) ? 3'd3 : (k <= 17) ? 3'd4 : (k == 18) ? 3'd2 : 3'd3;
         checks++;
         if (bus.state !== es || bus.ccc_en !== (k <= 2 || k >= 19) || bus.clk_ready !== (k <= 2 || k >= 20)) begin
            failures++;
            $display("FAIL lock_loss k=%0d state=%0d ccc_en=%b rdy=%b exp state=%0d ccc_en=%b rdy=%b",
                     k, bus.state, bus.ccc_en, bus.clk_ready, es, (k <= 2 || k >= 19), (k <= 2 || k >= 20));
         end
      end
      checks++;
      if (bus.retry_cnt !== 4'd1) begin
         failures++;
         $display("FAIL lock_loss_retry got=%0d exp=1", bus.retry_cnt);
      end
   endtask

   task automatic test_restart();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.state !== 3'd1 || bus.retry_cnt !== 4'd0) begin
         failures++;
         $display("FAIL restart state=%0d retry=%0d exp 1/0", bus.state, bus.retry_cnt);
      end
      step();
      checks++;
      if (bus.ccc_en !== 1'b0 || bus.clk_ready !== 1'b0) begin
         failures++;
         $display("FAIL restart_ccc ccc_en=%b rdy=%b exp 0/0", bus.ccc_en, bus.clk_ready);
      end
      for (int e = 2; e <= 11; e++) step();
      checks++;
      if (bus.state !== 3'd3 || bus.clk_ready !== 1'b1) begin
         failures++;
         $display("FAIL restart_relock state=%0d rdy=%b exp 3/1", bus.state, bus.clk_ready);
      end
   endtask

   task automatic test_start_stop();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      checks++;
      if (bus.state !== 3'd0) begin
         failures++;
         $display("FAIL start_stop_state got=%0d exp=0", bus.state);
      end
      step();
      checks++;
      if (bus.ccc_en !== 1'b0 || bus.clk_ready !== 1'b0 || bus.fault !== 1'b0) begin
         failures++;
         $display("FAIL start_stop_outputs ccc_en=%b rdy=%b fault=%b exp 0/0/0", bus.ccc_en, bus.clk_ready, bus.fault);
      end
   endtask

   task automatic test_timeout();
      logic [2:0] es, ps;
      logic [3:0] er;
      bus.pll_lock = 1'b0;
      step(); step(); step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      ps = 3'd1;
      for (int e = 1; e <= 101; e++) begin
         step();
         es = (e <= 7) ? 3'd1 : (e <= 27) ? 3'd2 : (e <= 43) ? 3'd4 : (e <= 63) ? 3'd2 :
              (e <= 79) ? 3'd4 : (e <= 99) ? 3'd2 : 3'd5;
         er = (e < 28) ? 4'd0 : (e < 64) ? 4'd1 : 4'd2;
         checks++;
         if (bus.state !== es || bus.retry_cnt !== er || bus.ccc_en !== (ps == 3'd2)) begin
            failures++;
            $display("FAIL timeout edge=%0d state=%0d retry=%0d ccc_en=%b exp state=%0d retry=%0d ccc_en=%b",
                     e, bus.state, bus.retry_cnt, bus.ccc_en, es, er, ps == 3'd2);
         end
         ps = es;
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.fault !== 1'b1 || bus.ccc_en !== 1'b0 || bus.state !== 3'd5) begin
            failures++;
            $display("FAIL fault_hold i=%0d fault=%b ccc_en=%b state=%0d exp 1/0/5", i, bus.fault, bus.ccc_en, bus.state);
         end
         step();
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.state !== 3'd1 || bus.retry_cnt !== 4'd0) begin
         failures++;
         $display("FAIL fault_exit state=%0d retry=%0d exp 1/0", bus.state, bus.retry_cnt);
      end
      step();
      checks++;
      if (bus.fault !== 1'b0) begin
         failures++;
         $display("FAIL fault_clear got=%b exp=0", bus.fault);
      end
      go_idle();
   endtask

   // lock_edge: edge after which PLL_LOCK is raised; 25 makes lock_s=1 at counter 19
   task automatic test_tie(input int lock_edge, input logic [2:0] exp_state, input logic [3:0] exp_retry);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 28; e++) begin
         step();
         if (e == lock_edge) bus.pll_lock = 1'b1;
         if (e == 27) begin
            checks++;
            if (bus.state !== 3'd2) begin
               failures++;
               $display("FAIL tie_window lock_edge=%0d state=%0d exp=2", lock_edge, bus.state);
            end
         end
      end
      checks++;
      if (bus.state !== exp_state || bus.retry_cnt !== exp_retry) begin
         failures++;
         $display("FAIL tie_result lock_edge=%0d state=%0d retry=%0d exp state=%0d retry=%0d",
                  lock_edge, bus.state, bus.retry_cnt, exp_state, exp_retry);
      end
      go_idle();
      bus.pll_lock = 1'b0;
      step(); step(); step();
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 12; e++) step();
      checks++;
      if (bus.ccc_en !== 1'b1 || bus.state !== 3'd2) begin
         failures++;
         $display("FAIL reset_mid_pre ccc_en=%b state=%0d exp 1/2", bus.ccc_en, bus.state);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({bus.ccc_en, bus.clk_ready, bus.fault, bus.state, bus.retry_cnt} !== 10'b0) begin
         failures++;
         $display("FAIL reset_mid_async got=%b exp=0", {bus.ccc_en, bus.clk_ready, bus.fault, bus.state, bus.retry_cnt});
      end
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (bus.state !== 3'd0 || bus.ccc_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold i=%0d state=%0d ccc_en=%b exp 0/0", i, bus.state, bus.ccc_en);
         end
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.pll_lock = 1'b0;
      test_reset();
      test_nominal();
      test_lock_loss();
      test_restart();
      test_start_stop();
      test_timeout();
      test_tie(25, 3'd3, 4'd0);
      test_tie(26, 3'd4, 4'd1);
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
